instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter NB_REG, default 32, datapath/PC/instruction width.
REQ-002 SHALL have parameter NB_IMEM_DEPTH, default 256, instruction memory size in bytes (power of 2, multiple of 4).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_dunit_clk_en  input  1  debug-unit step enable; 0 freezes PC, FSM and IF/ID register.
REQ-006 SHALL have port i_stall  input  1  hazard-unit stall; holds PC and IF/ID register.
REQ-007 SHALL have port i_flush  input  1  loads NOP into IF/ID register.
REQ-008 SHALL have port i_PCSrc  input  1  taken-branch select, from ID.
REQ-009 SHALL have port i_jsel  input  1  jump-register select (JR/JALR).
REQ-010 SHALL have port i_jump  input  1  jump-immediate select (J/JAL).
REQ-011 SHALL have port i_branch_target  input  NB_REG  branch target from ID.
REQ-012 SHALL have port i_pc_jsel  input  NB_REG  register jump target (rs data) from ID.
REQ-013 SHALL have port i_jump_addr  input  26  instr_index field of J/JAL.
REQ-014 SHALL have port i_dunit_we  input  1  debug loader byte write enable.
REQ-015 SHALL have port i_dunit_waddr  input  log2(NB_IMEM_DEPTH)  loader byte address.
REQ-016 SHALL have port i_dunit_wdata  input  8  loader byte data.
REQ-017 SHALL have port o_inst  output  NB_REG  IF/ID instruction to ID.
REQ-018 SHALL have port o_pcplus4  output  NB_REG  IF/ID PC+4 to ID.
REQ-019 SHALL have port o_pc  output  NB_REG  current PC register value (debug).
REQ-020 SHALL have port o_halt  output  1  high while FSM is in HALT.

Function
REQ-021 SHALL hold PC register; memory read address = PC[log2(NB_IMEM_DEPTH)-1:2]*4, upper PC bits ignored (address wraps modulo depth).
REQ-022 SHALL read words big-endian: byte at addr is bits [31:24], addr+3 is [7:0]; read is combinational from PC.
REQ-023 SHALL write i_dunit_wdata to byte i_dunit_waddr on each rising edge with i_dunit_we=1, regardless of i_dunit_clk_en, stall or FSM state.
REQ-024 SHALL define advance = i_dunit_clk_en & ~i_stall & state==RUN.
REQ-025 SHALL compute next PC on advance with priority i_PCSrc > i_jsel > i_jump > sequential: i_branch_target; i_pc_jsel; {PC+4[31:28], i_jump_addr, 2'b00}; PC+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-026 SHALL on advance latch o_inst = fetched word and o_pcplus4 = PC+4, or o_inst = 0 (NOP) with o_pcplus4 = PC+4 when i_flush=1.
REQ-027 SHALL, when i_dunit_clk_en=0 or i_stall=1, hold PC, o_inst, o_pcplus4 unchanged; i_flush is ignored while stalled.
REQ-028 SHALL implement FSM states RUN and HALT.
REQ-029 SHALL transition RUN -> HALT on advance when fetched word == 0xFFFFFFFF and i_PCSrc, i_jsel, i_jump all 0; that edge latches o_inst = 0, o_pcplus4 = PC+4 and leaves PC unchanged.
REQ-030 SHALL, when a redirect (i_PCSrc/i_jsel/i_jump) coincides with a fetched HALT word, take the redirect, latch NOP into IF/ID, stay in RUN.
REQ-031 SHALL remain in HALT until reset; in HALT PC, IF/ID register hold, o_halt=1, loader writes still accepted.
REQ-032 SHALL drive o_halt combinationally from state (1 in HALT only).
REQ-033 SHALL have one-cycle latency: word at PC appears on o_inst after the next advancing edge.

Reset
REQ-034 SHALL on i_reset=0 asynchronously set PC=0, o_inst=0, o_pcplus4=0, state=RUN, o_halt=0.
REQ-035 SHALL NOT clear instruction memory on reset; loaded program survives reset.
REQ-036 SHALL, on reset asserted mid-operation (including in HALT or during stall), abort immediately and restart fetch at address 0 on the first edge after release.

Verification
REQ-037 SHALL cover: load words 0x20010005,0x20020007 at bytes 0..7, reset, clk_en=1 -> o_inst=0x20010005/o_pcplus4=4, then 0x20020007/8, o_pc=8.
REQ-038 SHALL cover: i_stall=1 for 3 cycles at PC=4 -> PC, o_inst, o_pcplus4 unchanged; i_stall=0 resumes at PC=4 with i_flush=1 asserted during stall having no effect.
REQ-039 SHALL cover: PC=0x10, i_PCSrc=1, i_jsel=1, i_branch_target=0x40, i_flush=1 -> next PC=0x40, o_inst=0, o_pcplus4=0x14; i_jump=1, i_jump_addr=0x000003 at PC=0x40 -> PC=0x0C.
REQ-040 SHALL cover: 0xFFFFFFFF at byte 8 -> after fetch o_halt=1, o_inst=0, o_pc=8 held for 10 cycles; same word with i_jsel=1, i_pc_jsel=0x20 -> PC=0x20, o_halt=0.
REQ-041 SHALL cover: i_dunit_clk_en=0 with loader writes to byte 0 -> PC frozen, memory updated; async i_reset=0 between edges in HALT -> outputs zero immediately, program re-executes from 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, byte-loadable big-endian instruction memory,
// IF/ID pipeline register and a RUN/HALT controller that stops on an all-ones word.
module instruction_fetch #(
  parameter int NB_REG        = 32,
  parameter int NB_IMEM_DEPTH = 256
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_dunit_clk_en,
  input  logic                             i_stall,
  input  logic                             i_flush,
  input  logic                             i_PCSrc,
  input  logic                             i_jsel,
  input  logic                             i_jump,
  input  logic [NB_REG-1:0]                i_branch_target,
  input  logic [NB_REG-1:0]                i_pc_jsel,
  input  logic [25:0]                      i_jump_addr,
  input  logic                             i_dunit_we,
  input  logic [$clog2(NB_IMEM_DEPTH)-1:0] i_dunit_waddr,
  input  logic [7:0]                       i_dunit_wdata,
  output logic [NB_REG-1:0]                o_inst,
  output logic [NB_REG-1:0]                o_pcplus4,
  output logic [NB_REG-1:0]                o_pc,
  output logic                             o_halt
);

  localparam int NB_ADDR = $clog2(NB_IMEM_DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NB_REG-1:0] pc_q, pc_d;
  logic [NB_REG-1:0] inst_q, inst_d;
  logic [NB_REG-1:0] pcplus4_q, pcplus4_d;
  logic [7:0]        mem_q [NB_IMEM_DEPTH];

  logic [NB_REG-1:0] pc_plus4;
  logic [NB_REG-1:0] fetched;
  logic              advance;
  logic              redirect;
  logic              is_halt_word;

  // Loader writes are independent of stepping, stall and FSM state; memory has no reset.
  always_ff @(posedge i_clk) begin
    if (i_dunit_we) begin
      mem_q[i_dunit_waddr] <= i_dunit_wdata;
    end
  end

  // Word-aligned, wrapping read; byte at the lowest address is the most significant.
  assign fetched = {mem_q[{pc_q[NB_ADDR-1:2], 2'd0}],
                    mem_q[{pc_q[NB_ADDR-1:2], 2'd1}],
                    mem_q[{pc_q[NB_ADDR-1:2], 2'd2}],
                    mem_q[{pc_q[NB_ADDR-1:2], 2'd3}]};

  assign pc_plus4     = pc_q + NB_REG'(4);
  assign advance      = i_dunit_clk_en & ~i_stall & (state_q == ST_RUN);
  assign redirect     = i_PCSrc | i_jsel | i_jump;
  assign is_halt_word = (fetched == '1);

  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    pcplus4_d = pcplus4_q;
    if (advance) begin
      pcplus4_d = pc_plus4;
      inst_d    = (i_flush || is_halt_word) ? '0 : fetched;
      if (i_PCSrc) begin
        pc_d = i_branch_target;
      end else if (i_jsel) begin
        pc_d = i_pc_jsel;
      end else if (i_jump) begin
        pc_d = {pc_plus4[NB_REG-1 -: 4], i_jump_addr, 2'b00};
      end else if (!is_halt_word) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q      <= '0;
      inst_q    <= '0;
      pcplus4_q <= '0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HALT is terminal until reset; a redirect overrides a halt word.
  always_comb begin
    state_d = state_q;
    if (advance && is_halt_word && !redirect) begin
      state_d = ST_HALT;
    end
  end

  // FSM outputs
  always_comb begin
    o_halt = (state_q == ST_HALT);
  end

  assign o_inst    = inst_q;
  assign o_pcplus4 = pcplus4_q;
  assign o_pc      = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a behavioural fetch model.
module tb_instruction_fetch;

  localparam int DEPTH = 256;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_dunit_clk_en = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_PCSrc = 1'b0;
  logic        i_jsel = 1'b0;
  logic        i_jump = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic [31:0] i_pc_jsel = '0;
  logic [25:0] i_jump_addr = '0;
  logic        i_dunit_we = 1'b0;
  logic [7:0]  i_dunit_waddr = '0;
  logic [7:0]  i_dunit_wdata = '0;
  logic [31:0] o_inst;
  logic [31:0] o_pcplus4;
  logic [31:0] o_pc;
  logic        o_halt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem_m [DEPTH];
  logic [31:0] pc_m = '0;
  logic [31:0] inst_m = '0;
  logic [31:0] pcp4_m = '0;
  logic        halted_m = 1'b0;

  instruction_fetch #(.NB_REG(32), .NB_IMEM_DEPTH(DEPTH)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_dunit_clk_en  (i_dunit_clk_en),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_PCSrc         (i_PCSrc),
    .i_jsel          (i_jsel),
    .i_jump          (i_jump),
    .i_branch_target (i_branch_target),
    .i_pc_jsel       (i_pc_jsel),
    .i_jump_addr     (i_jump_addr),
    .i_dunit_we      (i_dunit_we),
    .i_dunit_waddr   (i_dunit_waddr),
    .i_dunit_wdata   (i_dunit_wdata),
    .o_inst          (o_inst),
    .o_pcplus4       (o_pcplus4),
    .o_pc            (o_pc),
    .o_halt          (o_halt)
  );

  // clock
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] fetch_m(input logic [31:0] pc);
    int base;
    base = int'(pc % 32'd256) - int'(pc % 32'd4);
    return {mem_m[base], mem_m[base + 1], mem_m[base + 2], mem_m[base + 3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".pc"}, o_pc, pc_m);
    chk({where, ".inst"}, o_inst, inst_m);
    chk({where, ".pcplus4"}, o_pcplus4, pcp4_m);
    chk({where, ".halt"}, 32'(o_halt), 32'(halted_m));
  endtask

  // One clock edge: advance the model from the current inputs, then compare.
  task automatic tick(input string where);
    logic [31:0] w;
    logic [31:0] p4;
    if (i_dunit_clk_en && !i_stall && !halted_m) begin
      w  = fetch_m(pc_m);
      p4 = pc_m + 32'd4;
      inst_m = (i_flush || w == 32'hFFFF_FFFF) ? 32'h0 : w;
      pcp4_m = p4;
      if (i_PCSrc)                  pc_m = i_branch_target;
      else if (i_jsel)              pc_m = i_pc_jsel;
      else if (i_jump)              pc_m = {p4[31:28], i_jump_addr, 2'b00};
      else if (w == 32'hFFFF_FFFF)  halted_m = 1'b1;
      else                          pc_m = p4;
    end
    if (i_dunit_we) mem_m[i_dunit_waddr] = i_dunit_wdata;
    @(posedge i_clk);
    #1;
    check_all(where);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    i_reset = 1'b0;
    #1;
    pc_m = '0; inst_m = '0; pcp4_m = '0; halted_m = 1'b0;
    check_all("reset");
    #1;
    i_reset = 1'b1;
  endtask

  task automatic clear_ctl();
    i_stall = 1'b0; i_flush = 1'b0; i_PCSrc = 1'b0; i_jsel = 1'b0; i_jump = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] addr, input logic [7:0] data);
    i_dunit_we = 1'b1; i_dunit_waddr = addr; i_dunit_wdata = data;
    tick("load");
    i_dunit_we = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] w);
    load_byte(addr,        w[31:24]);
    load_byte(addr + 8'd1, w[23:16]);
    load_byte(addr + 8'd2, w[15:8]);
    load_byte(addr + 8'd3, w[7:0]);
  endtask

  initial begin
    #1;
    do_reset();

    // fill memory with non-halt bytes, then place the directed program
    i_dunit_clk_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) load_byte(8'(a), 8'($urandom_range(0, 254)));
    load_word(8'h00, 32'h2001_0005);
    load_word(8'h04, 32'h2002_0007);
    load_word(8'h08, 32'hFFFF_FFFF);

    // sequential fetch
    do_reset();
    i_dunit_clk_en = 1'b1;
    tick("seq0");
    chk("seq0.inst_k", o_inst, 32'h2001_0005);
    chk("seq0.pcp4_k", o_pcplus4, 32'd4);
    tick("seq1");
    chk("seq1.inst_k", o_inst, 32'h2002_0007);
    chk("seq1.pcp4_k", o_pcplus4, 32'd8);
    chk("seq1.pc_k", o_pc, 32'd8);

    // halt word at byte 8
    tick("halt");
    chk("halt.halt_k", 32'(o_halt), 32'd1);
    chk("halt.inst_k", o_inst, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick("halt_hold");
      chk("halt_hold.pc_k", o_pc, 32'd8);
      chk("halt_hold.halt_k", 32'(o_halt), 32'd1);
    end

    // async reset while halted, program reruns from 0
    do_reset();
    chk("rst_halt.halt_k", 32'(o_halt), 32'd0);
    tick("rerun");
    chk("rerun.inst_k", o_inst, 32'h2001_0005);

    // stall at PC=4, flush ignored while stalled
    i_stall = 1'b1; i_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall.pc_k", o_pc, 32'd4);
      chk("stall.inst_k", o_inst, 32'h2001_0005);
      chk("stall.pcp4_k", o_pcplus4, 32'd4);
    end
    clear_ctl();
    tick("unstall");
    chk("unstall.inst_k", o_inst, 32'h2002_0007);
    chk("unstall.pc_k", o_pc, 32'd8);

    // redirect overrides halt word
    i_jsel = 1'b1; i_pc_jsel = 32'h20;
    tick("jr_halt");
    chk("jr_halt.pc_k", o_pc, 32'h20);
    chk("jr_halt.inst_k", o_inst, 32'd0);
    chk("jr_halt.halt_k", 32'(o_halt), 32'd0);

    // branch priority and jump
    i_pc_jsel = 32'h10;
    tick("to10");
    clear_ctl();
    i_PCSrc = 1'b1; i_jsel = 1'b1; i_flush = 1'b1;
    i_branch_target = 32'h40; i_pc_jsel = 32'h80;
    tick("branch");
    chk("branch.pc_k", o_pc, 32'h40);
    chk("branch.inst_k", o_inst, 32'd0);
    chk("branch.pcp4_k", o_pcplus4, 32'h14);
    clear_ctl();
    i_jump = 1'b1; i_jump_addr = 26'h000003;
    tick("jump");
    chk("jump.pc_k", o_pc, 32'h0C);
    clear_ctl();

    // frozen PC while loading byte 0..3
    i_dunit_clk_en = 1'b0;
    load_word(8'h00, 32'h1234_5678);
    chk("frozen.pc_k", o_pc, 32'h0C);
    do_reset();
    i_dunit_clk_en = 1'b1;
    tick("reload");
    chk("reload.inst_k", o_inst, 32'h1234_5678);

    // reset during stall
    i_stall = 1'b1;
    tick("pre_rst_stall");
    do_reset();
    i_stall = 1'b0;
    tick("post_rst_stall");
    chk("post_rst_stall.pc_k", o_pc, 32'd4);

    // randomized phase
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0 || (halted_m && $urandom_range(0, 9) == 0)) do_reset();
      i_dunit_clk_en  = ($urandom_range(0, 9) != 0);
      i_stall         = ($urandom_range(0, 4) == 0);
      i_flush         = ($urandom_range(0, 9) == 0);
      i_PCSrc         = ($urandom_range(0, 7) == 0);
      i_jsel          = ($urandom_range(0, 7) == 0);
      i_jump          = ($urandom_range(0, 7) == 0);
      i_branch_target = $urandom;
      i_pc_jsel       = $urandom;
      i_jump_addr     = 26'($urandom);
      i_dunit_we      = ($urandom_range(0, 3) == 0);
      i_dunit_waddr   = 8'($urandom);
      i_dunit_wdata   = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
